// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_*       : default parameter values used by the top and the scoreboard.
//   addr_width  : register address width for a given register count.
package regfile_mp_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NWR  = 2;

  // Number of address bits needed to name NREG registers (NREG is a power of two, >= 2).
  function automatic int addr_width(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy scoreboard for the register file.
// Ports:
//   clk, rstn  : clock (posedge) and asynchronous active-low reset
//   w_en       : per-write-port enable; a write clears the busy bit of its address
//   w_addr     : write addresses, port k at [k*AW +: AW]
//   sb_set     : mark sb_addr busy (a new producer has been issued)
//   sb_addr    : register to mark busy
//   busy_vec   : registered scoreboard, bit i = register i busy
//   busy_next  : scoreboard value after this cycle's clears and sets (used by read bypass)
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int NWR  = DEF_NWR,
  parameter int AW   = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NWR-1:0]    w_en,
  input  logic [NWR*AW-1:0] w_addr,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [NREG-1:0]   busy_next
);

  // Clears are applied first and the set last, so a producer issued on the
  // same edge as the previous producer's writeback leaves the register busy.
  always_comb begin
    busy_next = busy_vec;
    for (int k = 0; k < NWR; k++) begin
      if (w_en[k]) begin
        busy_next[w_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (sb_set && (sb_addr != '0)) begin
      busy_next[sb_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file: NRD registered read ports,
// NWR write ports (higher index wins on an address collision), x0 hard-wired
// to zero, write-first bypass into the read ports and a busy scoreboard.
// Ports:
//   clk, rstn : clock (posedge) and asynchronous active-low reset
//   r_en      : per-read-port enable; disabled ports hold r_data/r_busy
//   r_addr    : read addresses, port p at [p*AW +: AW]
//   r_data    : registered read data, port p at [p*XLEN +: XLEN]
//   r_busy    : registered busy flag of the register read on port p
//   w_en      : per-write-port enable
//   w_addr    : write addresses, port k at [k*AW +: AW]
//   w_data    : write data, port k at [k*XLEN +: XLEN]
//   sb_set    : mark sb_addr busy
//   sb_addr   : register to mark busy
//   busy_vec  : registered scoreboard
// Handshake: there is no valid/ready pairing; every enable is a one-cycle
// request that is always accepted on the next posedge, with no back-pressure.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR,
  localparam int AW  = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD-1:0]      r_en,
  input  logic [NRD*AW-1:0]   r_addr,
  output logic [NRD*XLEN-1:0] r_data,
  output logic [NRD-1:0]      r_busy,
  input  logic [NWR-1:0]      w_en,
  input  logic [NWR*AW-1:0]   w_addr,
  input  logic [NWR*XLEN-1:0] w_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] mem      [NREG];
  logic [XLEN-1:0] mem_next [NREG];
  logic [NREG-1:0] busy_next;

  regfile_mp_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rstn      (rstn),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .busy_vec  (busy_vec),
    .busy_next (busy_next)
  );

  // File contents after this edge's writes. Ports are applied in ascending
  // order so the highest-indexed port to an address overwrites the others.
  // Entry 0 is forced to zero, which drops x0 writes and makes x0 reads zero.
  always_comb begin
    mem_next = mem;
    for (int k = 0; k < NWR; k++) begin
      if (w_en[k] && (w_addr[k*AW +: AW] != '0)) begin
        mem_next[w_addr[k*AW +: AW]] = w_data[k*XLEN +: XLEN];
      end
    end
    mem_next[0] = '0;
  end

  // Reads sample the post-write file and post-update scoreboard, giving a
  // write-first bypass with the same priority as the storage update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '{default: '0};
      r_data <= '0;
      r_busy <= '0;
    end else begin
      mem <= mem_next;
      for (int p = 0; p < NRD; p++) begin
        if (r_en[p]) begin
          r_data[p*XLEN +: XLEN] <= mem_next[r_addr[p*AW +: AW]];
          r_busy[p]              <= busy_next[r_addr[p*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling clock edge.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NRD-1:0]      r_en;
  logic [NRD*AW-1:0]   r_addr;
  logic [NRD*XLEN-1:0] r_data;
  logic [NRD-1:0]      r_busy;
  logic [NWR-1:0]      w_en;
  logic [NWR*AW-1:0]   w_addr;
  logic [NWR*XLEN-1:0] w_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [NREG-1:0]     busy_vec;

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .r_en     (r_en),
    .r_addr   (r_addr),
    .r_data   (r_data),
    .r_busy   (r_busy),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy_vec (busy_vec)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_mem   [NREG];
  logic [NREG-1:0] m_busy;
  logic [XLEN-1:0] m_rdata [NRD];
  logic [NRD-1:0]  m_rbusy;

  // Value register a holds once this edge's writes land: the highest port
  // writing a wins; x0 is always zero.
  function automatic logic [XLEN-1:0] post_val(input int a);
    if (a == 0) return '0;
    for (int k = NWR - 1; k >= 0; k--) begin
      if (w_en[k] && (int'(w_addr[k*AW +: AW]) == a)) return w_data[k*XLEN +: XLEN];
    end
    return m_mem[a];
  endfunction

  // Busy state of register a after this edge: a new issue wins over a
  // writeback, a writeback clears, otherwise unchanged; x0 never busy.
  function automatic logic post_busy(input int a);
    if (a == 0) return 1'b0;
    if (sb_set && (int'(sb_addr) == a)) return 1'b1;
    for (int k = 0; k < NWR; k++) begin
      if (w_en[k] && (int'(w_addr[k*AW +: AW]) == a)) return 1'b0;
    end
    return m_busy[a];
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) m_mem[i] <= '0;
      m_busy <= '0;
      for (int p = 0; p < NRD; p++) m_rdata[p] <= '0;
      m_rbusy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  <= post_val(i);
        m_busy[i] <= post_busy(i);
      end
      for (int p = 0; p < NRD; p++) begin
        if (r_en[p]) begin
          m_rdata[p] <= post_val(int'(r_addr[p*AW +: AW]));
          m_rbusy[p] <= post_busy(int'(r_addr[p*AW +: AW]));
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("model_r_data%0d", p), r_data[p*XLEN +: XLEN], m_rdata[p]);
        check($sformatf("model_r_busy%0d", p), XLEN'(r_busy[p]), XLEN'(m_rbusy[p]));
      end
      check("model_busy_vec", XLEN'(busy_vec), XLEN'(m_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    r_en = '0; r_addr = '0; w_en = '0; w_addr = '0; w_data = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic wr(input int k, input int a, input logic [XLEN-1:0] d);
    w_en[k] = 1'b1;
    w_addr[k*AW +: AW] = AW'(a);
    w_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input int a);
    r_en[p] = 1'b1;
    r_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic sb(input int a);
    sb_set = 1'b1;
    sb_addr = AW'(a);
  endtask

  // One clock edge with the currently driven inputs; returns 1 time unit
  // after the edge with inputs cleared.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cmp_on = 1'b1;
    check("reset_r_data", r_data[XLEN-1:0], '0);
    check("reset_busy_vec", XLEN'(busy_vec), '0);

    // 1. reset mid-operation
    wr(0, 5, 64'hDEAD); sb(5); tick();
    check("t1_busy_vec", XLEN'(busy_vec), 64'h20);
    rd(0, 5); tick();
    check("t1_rd5", r_data[XLEN-1:0], 64'hDEAD);
    check("t1_rbusy5", XLEN'(r_busy[0]), 64'h1);
    #1 rstn = 1'b0;
    #1;
    check("t1_async_r_data", r_data[XLEN-1:0], '0);
    check("t1_async_busy_vec", XLEN'(busy_vec), '0);
    check("t1_async_r_busy", XLEN'(r_busy), '0);
    #4 rstn = 1'b1;
    rd(0, 5); tick();
    check("t1_rd5_after_reset", r_data[XLEN-1:0], '0);

    // 2. write then read, x0 writes dropped
    wr(0, 3, 64'h1234); tick();
    rd(0, 3); tick();
    check("t2_rd3", r_data[XLEN-1:0], 64'h1234);
    wr(1, 0, 64'hFF); rd(1, 0); tick();
    check("t2_rd0_bypass", r_data[XLEN +: XLEN], '0);
    rd(0, 0); tick();
    check("t2_rd0", r_data[XLEN-1:0], '0);

    // 3. same-address writes on both ports, bypassed to both read ports
    wr(0, 7, 64'h11); wr(1, 7, 64'h22); rd(0, 7); rd(1, 7); tick();
    check("t3_rd7_p0", r_data[XLEN-1:0], 64'h22);
    check("t3_rd7_p1", r_data[XLEN +: XLEN], 64'h22);
    rd(0, 7); tick();
    check("t3_mem7", r_data[XLEN-1:0], 64'h22);

    // 4. scoreboard set, cleared by writeback seen by a bypassing read
    sb(9); tick();
    check("t4_busy9", XLEN'(busy_vec[9]), 64'h1);
    wr(0, 9, 64'h55); rd(0, 9); tick();
    check("t4_rd9", r_data[XLEN-1:0], 64'h55);
    check("t4_rbusy9", XLEN'(r_busy[0]), '0);
    check("t4_busy9_clr", XLEN'(busy_vec[9]), '0);
    wr(1, 10, 64'hAA); sb(10); rd(1, 10); tick();
    check("t4_rd10", r_data[XLEN +: XLEN], 64'hAA);
    check("t4_rbusy10_reset", XLEN'(r_busy[1]), 64'h1);

    // 5. set wins over clear; sb_set x0 ignored
    sb(4); wr(1, 4, 64'h44); tick();
    check("t5_busy4", XLEN'(busy_vec[4]), 64'h1);
    rd(0, 4); tick();
    check("t5_rd4", r_data[XLEN-1:0], 64'h44);
    wr(0, 4, 64'h45); wr(1, 10, 64'hAB); tick();
    sb(0); tick();
    check("t5_busy_vec_zero", XLEN'(busy_vec), '0);

    // 6. read port holds while disabled
    wr(0, 2, 64'hA1); rd(0, 2); tick();
    check("t6_rd2", r_data[XLEN-1:0], 64'hA1);
    for (int i = 1; i <= 3; i++) begin
      wr(0, 2, 64'hB0 + 64'(i)); tick();
      check("t6_hold", r_data[XLEN-1:0], 64'hA1);
    end
    rd(0, 2); tick();
    check("t6_rd2_new", r_data[XLEN-1:0], 64'hB3);

    // sweep every register through alternating write ports
    for (int i = 1; i < NREG; i++) begin
      wr(i % 2, i, {32'(i), 32'hC0FF_EE00 + 32'(i)});
      rd(0, i);
      rd(1, i - 1);
      tick();
    end
    rd(0, 31); rd(1, 17); tick();
    check("sweep_rd31", r_data[XLEN-1:0], 64'h0000_001F_C0FF_EE1F);
    check("sweep_rd17", r_data[XLEN +: XLEN], 64'h0000_0011_C0FF_EE11);

    @(negedge clk);
    #1;
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
